// File: rtl/force_write_arbiter_pkg.sv
// Shared types and field helpers for the force write arbiter.
// A buffer entry is {tag, pid, fz, fy, fx} with fx at the LSB.
package force_write_arbiter_pkg;

  localparam int DATA_WIDTH         = 32;
  localparam int PARTICLE_ID_WIDTH  = 7;
  localparam int NUM_FILTER         = 7;
  localparam int FORCE_BUFFER_WIDTH = 3*DATA_WIDTH + PARTICLE_ID_WIDTH + 1;

  // Field offsets inside one buffer entry
  localparam int FORCE_LSB = 0;
  localparam int PID_LSB   = 3*DATA_WIDTH;
  localparam int TAG_BIT   = PID_LSB + PARTICLE_ID_WIDTH;

  // Packed struct: first member lands at the MSB, matching the entry layout
  typedef struct packed {
    logic                         tag;
    logic [PARTICLE_ID_WIDTH-1:0] pid;
    logic [DATA_WIDTH-1:0]        fz;
    logic [DATA_WIDTH-1:0]        fy;
    logic [DATA_WIDTH-1:0]        fx;
  } force_entry_t;

  // Hazard key: a write targets the cache line selected by {tag, pid}
  typedef struct packed {
    logic                         tag;
    logic [PARTICLE_ID_WIDTH-1:0] pid;
  } force_key_t;

  function automatic logic get_tag(input force_entry_t e);
    return e[TAG_BIT];
  endfunction

  function automatic logic [PARTICLE_ID_WIDTH-1:0] get_pid(input force_entry_t e);
    return e[PID_LSB +: PARTICLE_ID_WIDTH];
  endfunction

  function automatic logic [3*DATA_WIDTH-1:0] get_force(input force_entry_t e);
    return e[FORCE_LSB +: 3*DATA_WIDTH];
  endfunction

  function automatic force_key_t get_key(input force_entry_t e);
    force_key_t k;
    k.tag = get_tag(e);
    k.pid = get_pid(e);
    return k;
  endfunction

endpackage

// File: rtl/force_write_arbiter_if.sv
// Buffer-side and force-cache-side signals of the force write arbiter.
// master = force buffers + force cache (environment), slave = arbiter.
interface force_write_arbiter_if
  import force_write_arbiter_pkg::*;
  ;
  force_entry_t [NUM_FILTER-1:0]  force_data_in;
  logic [NUM_FILTER-1:0]          force_valid_in;
  logic                           fc_stall;
  logic [NUM_FILTER-1:0]          write_success;
  logic                           fc_wr_valid;
  logic                           fc_wr_tag;
  logic [PARTICLE_ID_WIDTH-1:0]   fc_wr_id;
  logic [3*DATA_WIDTH-1:0]        fc_wr_force;

  modport master (
    output force_data_in, force_valid_in, fc_stall,
    input  write_success, fc_wr_valid, fc_wr_tag, fc_wr_id, fc_wr_force
  );

  modport slave (
    input  force_data_in, force_valid_in, fc_stall,
    output write_success, fc_wr_valid, fc_wr_tag, fc_wr_id, fc_wr_force
  );

endinterface

// File: rtl/force_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins,
// pointer moves past the winner and holds when nothing is granted.
module rr_arbiter #(
  parameter  int N  = 7,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] ptr;

  // Scan from the pointer with wrap, take the first requester
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  // Pointer advances to the slot after the winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr <= '0;
    else if (grant_any)
      ptr <= (int'(grant_idx) == N-1) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/force_write_arbiter.sv
// Drains the force buffers of one PE into the single-port force cache.
// One entry per cycle, round-robin, with read-after-write hazard blocking
// against writes still inside the accumulate pipeline.
module force_write_arbiter
  import force_write_arbiter_pkg::*;
#(
  parameter int ACC_LATENCY = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  force_write_arbiter_if.slave bus,
  output logic                 arb_idle,
  output logic [CNT_WIDTH-1:0] write_count
);

  localparam int IW = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1;
  // Only the first ACC_LATENCY-1 slots block a reissue: a key granted at
  // cycle t may be granted again at cycle t+ACC_LATENCY.
  localparam int KW = (ACC_LATENCY > 1) ? ACC_LATENCY-1 : 1;

  logic [ACC_LATENCY-1:0]  vld_pipe;
  force_key_t [KW-1:0]     key_pipe;
  logic [NUM_FILTER-1:0]   hazard;
  logic [NUM_FILTER-1:0]   req;
  logic [NUM_FILTER-1:0]   grant;
  logic [IW-1:0]           grant_idx;
  logic                    grant_any;
  force_entry_t            sel;

  // Match each head entry against the blocking part of the window
  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_FILTER; i++)
      for (int k = 0; k < ACC_LATENCY-1; k++)
        if (vld_pipe[k] && key_pipe[k] == get_key(bus.force_data_in[i]))
          hazard[i] = 1'b1;
  end

  assign req = bus.force_valid_in & ~hazard & {NUM_FILTER{~bus.fc_stall}};

  rr_arbiter #(.N(NUM_FILTER)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign sel = bus.force_data_in[grant_idx];

  // Pop strobes are suppressed while reset is held so no buffer drains
  assign bus.write_success = grant & {NUM_FILTER{rst}};

  assign arb_idle = !rst ||
                    ((bus.force_valid_in == '0) && !(|vld_pipe) && !bus.fc_wr_valid);

  // Hazard window: shifts on every unstalled cycle, frozen under stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      key_pipe <= '0;
    end else if (!bus.fc_stall) begin
      vld_pipe[0] <= grant_any;
      for (int k = 1; k < ACC_LATENCY; k++)
        vld_pipe[k] <= vld_pipe[k-1];
      if (ACC_LATENCY > 1)
        key_pipe[0] <= get_key(sel);
      for (int k = 1; k < ACC_LATENCY-1; k++)
        key_pipe[k] <= key_pipe[k-1];
    end
  end

  // Issue register; data holds when nothing is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.fc_wr_valid <= 1'b0;
      bus.fc_wr_tag   <= 1'b0;
      bus.fc_wr_id    <= '0;
      bus.fc_wr_force <= '0;
      write_count     <= '0;
    end else begin
      bus.fc_wr_valid <= grant_any;
      if (grant_any) begin
        bus.fc_wr_tag   <= get_tag(sel);
        bus.fc_wr_id    <= get_pid(sel);
        bus.fc_wr_force <= get_force(sel);
        write_count     <= write_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_force_write_arbiter.sv
// Scoreboard bench for force_write_arbiter: stimulus computes per-cycle
// expectations from a behavioural model, a monitor compares them.
module tb_force_write_arbiter;
  import force_write_arbiter_pkg::*;

  localparam int NF = NUM_FILTER;
  localparam int L  = 4;
  localparam int CW = 16;

  typedef struct {
    logic [NF-1:0]                ws;
    logic                         v;
    logic                         tag;
    logic [PARTICLE_ID_WIDTH-1:0] pid;
    logic [3*DATA_WIDTH-1:0]      frc;
    logic [CW-1:0]                cnt;
    logic                         idle;
  } exp_t;

  typedef struct {
    logic                         tag;
    logic [PARTICLE_ID_WIDTH-1:0] pid;
    int                           u;
  } hist_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          arb_idle;
  logic [CW-1:0] write_count;

  force_write_arbiter_if bus();

  force_write_arbiter #(.ACC_LATENCY(L), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .arb_idle    (arb_idle),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  // Bench-side show-ahead buffers and model state
  force_entry_t bufq [NF][$];
  hist_t        hist [$];
  exp_t         expq [$];
  int           m_ptr, m_u;
  logic         m_v, m_tag;
  logic [PARTICLE_ID_WIDTH-1:0] m_pid;
  logic [3*DATA_WIDTH-1:0]      m_frc;
  logic [CW-1:0]                m_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic force_entry_t mk(input logic tag, input int pid);
    force_entry_t e;
    e.tag = tag;
    e.pid = PARTICLE_ID_WIDTH'(pid);
    e.fz  = $urandom;
    e.fy  = $urandom;
    e.fx  = $urandom;
    return e;
  endfunction

  task automatic push(input int b, input logic tag, input int pid);
    bufq[b].push_back(mk(tag, pid));
  endtask

  // A key written within the last L-1 unstalled cycles may not be reissued
  function automatic bit blocked(input force_entry_t e);
    foreach (hist[j])
      if (hist[j].tag == e.tag && hist[j].pid == e.pid &&
          m_u - hist[j].u >= 1 && m_u - hist[j].u <= L-1) return 1'b1;
    return 1'b0;
  endfunction

  // A write stays in flight for L unstalled cycles after its grant
  function automatic bit in_flight();
    foreach (hist[j])
      if (m_u - hist[j].u >= 1 && m_u - hist[j].u <= L) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_u = 0; m_v = 0; m_tag = 0; m_pid = '0; m_frc = '0; m_cnt = '0;
    hist.delete();
  endtask

  // One clock cycle: drive at the falling edge, predict, advance model
  task automatic step(input bit rst_v, input bit stall_v, input logic [NF-1:0] mask);
    exp_t e;
    logic [NF-1:0] vin;
    int g;
    @(negedge clk);
    rst = rst_v;
    bus.fc_stall = stall_v;
    for (int i = 0; i < NF; i++) begin
      vin[i] = mask[i] && (bufq[i].size() > 0);
      bus.force_data_in[i] = vin[i] ? bufq[i][0] : mk($urandom_range(0, 1), $urandom_range(0, 127));
    end
    bus.force_valid_in = vin;
    if (!rst_v) begin
      model_reset();
      e = '{ws: '0, v: 1'b0, tag: 1'b0, pid: '0, frc: '0, cnt: '0, idle: 1'b1};
    end else begin
      e.v = m_v; e.tag = m_tag; e.pid = m_pid; e.frc = m_frc; e.cnt = m_cnt;
      e.idle = (vin == '0) && !in_flight() && !m_v;
      g = -1;
      if (!stall_v)
        for (int off = 0; off < NF; off++) begin
          int i;
          i = (m_ptr + off) % NF;
          if (g < 0 && vin[i] && !blocked(bufq[i][0])) g = i;
        end
      e.ws = '0;
      if (g >= 0) e.ws[g] = 1'b1;
      if (stall_v) m_v = 1'b0;
      else begin
        if (g >= 0) begin
          force_entry_t h;
          h = bufq[g].pop_front();
          m_v = 1'b1; m_tag = h.tag; m_pid = h.pid; m_frc = {h.fz, h.fy, h.fx};
          m_cnt = m_cnt + 1'b1;
          m_ptr = (g + 1) % NF;
          hist.push_back('{tag: h.tag, pid: h.pid, u: m_u});
        end else m_v = 1'b0;
        m_u++;
        while (hist.size() > 0 && m_u - hist[0].u > L) void'(hist.pop_front());
      end
    end
    expq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("write_success", 128'(bus.write_success), 128'(e.ws));
        chk("fc_wr_valid",   128'(bus.fc_wr_valid),   128'(e.v));
        chk("fc_wr_tag",     128'(bus.fc_wr_tag),     128'(e.tag));
        chk("fc_wr_id",      128'(bus.fc_wr_id),      128'(e.pid));
        chk("fc_wr_force",   128'(bus.fc_wr_force),   128'(e.frc));
        chk("write_count",   128'(write_count),       128'(e.cnt));
        chk("arb_idle",      128'(arb_idle),          128'(e.idle));
      end
    end
  end

  localparam logic [NF-1:0] ALL = '1;

  initial begin
    rst = 1'b0;
    bus.fc_stall = 1'b0;
    bus.force_valid_in = '0;
    bus.force_data_in = '0;
    model_reset();

    // Reset held, then released with nothing queued
    repeat (3) step(0, 0, ALL);
    repeat (2) step(1, 0, ALL);

    // Single entry on buffer 3
    push(3, 0, 5);
    repeat (6) step(1, 0, ALL);

    // Fairness: all buffers held valid with distinct ids
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < NF; b++) push(b, 0, 10*k + b + 40);
    repeat (25) step(1, 0, ALL);

    // Hazard: same pid twice on buffer 0, alone
    push(0, 0, 9); push(0, 0, 9);
    repeat (8) step(1, 0, ALL);
    // Hazard with buffer 1 filling the gap
    push(0, 1, 9); push(0, 1, 9);
    push(1, 0, 20); push(1, 0, 21); push(1, 0, 22);
    repeat (10) step(1, 0, ALL);

    // Stall for 3 cycles with two buffers pending
    push(2, 0, 30); push(5, 0, 31); push(2, 0, 32);
    repeat (3) step(1, 1, ALL);
    repeat (6) step(1, 0, ALL);

    // Same pid, different tags on different buffers
    push(4, 0, 2); push(6, 1, 2);
    repeat (5) step(1, 0, ALL);

    // Randomised traffic with collisions, stalls and dropping valids
    for (int c = 0; c < 2000; c++) begin
      logic [NF-1:0] msk;
      for (int b = 0; b < NF; b++) begin
        if (bufq[b].size() < 4 && $urandom_range(0, 9) < 3)
          push(b, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
        msk[b] = ($urandom_range(0, 9) != 0);
      end
      step(1, ($urandom_range(0, 9) == 0), msk);
    end

    // Reset mid-stream with valid inputs present
    for (int b = 0; b < NF; b++) push(b, 0, b);
    step(1, 0, ALL);
    repeat (2) step(0, 0, ALL);
    repeat (40) step(1, 0, ALL);

    @(negedge clk);
    @(negedge clk);
    #3;
    if (expq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left unchecked", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
